// File: rtl/captura_digitos_pkg.sv
// Shared codes, debounce state type and key-class helper for the digit-capture block.
package captura_pkg;

  localparam logic [4:0] COD_NADA    = 5'd16;
  localparam logic [3:0] COD_BORRAR  = 4'hA;
  localparam logic [3:0] COD_ENTER   = 4'hE;
  localparam logic [3:0] COD_LIMPIAR = 4'hF;

  typedef enum logic [1:0] {
    LIBRE      = 2'd0,
    CONFIRMA   = 2'd1,
    PRESIONADA = 2'd2
  } estado_t;

  function automatic logic es_digito(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

endpackage

// File: rtl/captura_digitos_if.sv
// Committed-entry output channel: data plus valid/ready handshake.
interface captura_digitos_if #(
  parameter int N_DIG = 4
);
  logic [4*N_DIG-1:0] dato_out;
  logic               valid_out;
  logic               ready_in;

  modport master (output dato_out, output valid_out, input ready_in);
  modport slave  (input dato_out, input valid_out, output ready_in);
endinterface

// File: rtl/captura_digitos_antirrebote_tecla.sv
// Press debouncer: turns a stream of scanned key samples into one tecla_ok pulse per press.
module antirrebote_tecla
  import captura_pkg::*;
#(
  parameter int ESTABLE    = 3,
  parameter int REL_CICLOS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] codigo,
  input  logic       activo,
  output logic       tecla_ok,
  output logic [3:0] tecla
);

  localparam int QW = $clog2(REL_CICLOS + 1);
  localparam int NW = $clog2(ESTABLE + 1);
  localparam logic [QW-1:0] Q_MAX = QW'(REL_CICLOS);
  localparam logic [NW-1:0] N_OBJ = NW'(ESTABLE);

  estado_t         estado_r, estado_next_s;
  logic [QW-1:0]   q_r, q_next_s;
  logic [NW-1:0]   n_r, n_next_s;
  logic [3:0]      cand_r, cand_next_s;
  logic            valido_s;
  logic            quieto_s;
  logic            tecla_ok_s;

  // Quiet counter: cleared by any row activity, saturates at the release threshold.
  always_comb begin
    q_next_s = q_r;
    if (activo) begin
      q_next_s = QW'(0);
    end else if (q_r == Q_MAX) begin
      q_next_s = q_r;
    end else begin
      q_next_s = q_r + QW'(1);
    end
  end

  assign valido_s = activo && (codigo < COD_NADA);
  assign quieto_s = (q_next_s == Q_MAX);

  // Next-state and acceptance decode; acceptance is combinational so the buffer updates on the same edge.
  always_comb begin
    estado_next_s = estado_r;
    n_next_s      = n_r;
    cand_next_s   = cand_r;
    tecla_ok_s    = 1'b0;
    case (estado_r)
      LIBRE: begin
        if (valido_s) begin
          cand_next_s = codigo[3:0];
          n_next_s    = NW'(1);
          if (n_next_s == N_OBJ) begin
            tecla_ok_s    = 1'b1;
            estado_next_s = PRESIONADA;
          end else begin
            estado_next_s = CONFIRMA;
          end
        end else begin
          estado_next_s = LIBRE;
        end
      end
      CONFIRMA: begin
        if (valido_s) begin
          if (codigo[3:0] == cand_r) begin
            n_next_s = n_r + NW'(1);
          end else begin
            cand_next_s = codigo[3:0];
            n_next_s    = NW'(1);
          end
          if (n_next_s == N_OBJ) begin
            tecla_ok_s    = 1'b1;
            estado_next_s = PRESIONADA;
          end else begin
            estado_next_s = CONFIRMA;
          end
        end else if (quieto_s) begin
          estado_next_s = LIBRE;
          n_next_s      = NW'(0);
        end else begin
          estado_next_s = CONFIRMA;
        end
      end
      PRESIONADA: begin
        if (quieto_s) begin
          estado_next_s = LIBRE;
          n_next_s      = NW'(0);
        end else begin
          estado_next_s = PRESIONADA;
        end
      end
      default: begin
        estado_next_s = LIBRE;
        n_next_s      = NW'(0);
      end
    endcase
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_r <= LIBRE;
      q_r      <= QW'(0);
      n_r      <= NW'(0);
      cand_r   <= 4'd0;
    end else begin
      estado_r <= estado_next_s;
      q_r      <= q_next_s;
      n_r      <= n_next_s;
      cand_r   <= cand_next_s;
    end
  end

  assign tecla_ok = tecla_ok_s;
  assign tecla    = cand_next_s;

endmodule

// File: rtl/captura_digitos.sv
// Keypad digit-entry buffer with debounced input and valid/ready commit channel.
// Optional build macro CAPTURA_ECO_EN adds the eco/eco_tecla accepted-key echo.
module captura_digitos
  import captura_pkg::*;
#(
  parameter int N_DIG      = 4,
  parameter int ESTABLE    = 3,
  parameter int REL_CICLOS = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [4:0]                 codigo,
  input  logic                       activo,
  output logic [4*N_DIG-1:0]         digitos,
  output logic [$clog2(N_DIG+1)-1:0] cuenta,
  output logic                       rechazo,
  captura_digitos_if.master          sal
`ifdef CAPTURA_ECO_EN
  ,
  output logic                       eco,
  output logic [4:0]                 eco_tecla
`endif
);

  localparam int DW = 4 * N_DIG;
  localparam int CW = $clog2(N_DIG + 1);
  localparam logic [CW-1:0] C_MAX = CW'(N_DIG);

  logic            tecla_ok_s;
  logic [3:0]      tecla_s;
  logic [DW-1:0]   digitos_r, digitos_next_s;
  logic [CW-1:0]   cuenta_r, cuenta_next_s;
  logic [DW-1:0]   dato_r, dato_next_s;
  logic            valid_r, valid_next_s;
  logic            rechazo_r, rechazo_next_s;
  logic            libre_s;

  antirrebote_tecla #(
    .ESTABLE    (ESTABLE),
    .REL_CICLOS (REL_CICLOS)
  ) u_antirrebote (
    .clk      (clk),
    .rst      (rst),
    .codigo   (codigo),
    .activo   (activo),
    .tecla_ok (tecla_ok_s),
    .tecla    (tecla_s)
  );

  // The slot is reusable if empty or being drained on this very edge.
  assign libre_s = !valid_r || sal.ready_in;

  // Buffer edit and commit decode for the accepted key.
  always_comb begin
    digitos_next_s = digitos_r;
    cuenta_next_s  = cuenta_r;
    dato_next_s    = dato_r;
    valid_next_s   = valid_r && !sal.ready_in;
    rechazo_next_s = 1'b0;
    if (tecla_ok_s) begin
      case (tecla_s)
        COD_BORRAR: begin
          digitos_next_s = digitos_r >> 4'd4;
          if (cuenta_r != CW'(0)) begin
            cuenta_next_s = cuenta_r - CW'(1);
          end else begin
            cuenta_next_s = CW'(0);
          end
        end
        COD_LIMPIAR: begin
          digitos_next_s = DW'(0);
          cuenta_next_s  = CW'(0);
        end
        COD_ENTER: begin
          if (cuenta_r == CW'(0)) begin
            rechazo_next_s = 1'b0;
          end else if (libre_s) begin
            dato_next_s    = digitos_r;
            valid_next_s   = 1'b1;
            digitos_next_s = DW'(0);
            cuenta_next_s  = CW'(0);
          end else begin
            rechazo_next_s = 1'b1;
          end
        end
        default: begin
          // Codes B, C and D fall through here and are ignored.
          if (es_digito(tecla_s)) begin
            if (cuenta_r < C_MAX) begin
              digitos_next_s = {digitos_r[DW-5:0], tecla_s};
              cuenta_next_s  = cuenta_r + CW'(1);
            end else begin
              rechazo_next_s = 1'b1;
            end
          end else begin
            rechazo_next_s = 1'b0;
          end
        end
      endcase
    end else begin
      rechazo_next_s = 1'b0;
    end
  end

  // Buffer, output slot and reject pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      digitos_r <= DW'(0);
      cuenta_r  <= CW'(0);
      dato_r    <= DW'(0);
      valid_r   <= 1'b0;
      rechazo_r <= 1'b0;
    end else begin
      digitos_r <= digitos_next_s;
      cuenta_r  <= cuenta_next_s;
      dato_r    <= dato_next_s;
      valid_r   <= valid_next_s;
      rechazo_r <= rechazo_next_s;
    end
  end

  assign digitos       = digitos_r;
  assign cuenta        = cuenta_r;
  assign rechazo       = rechazo_r;
  assign sal.dato_out  = dato_r;
  assign sal.valid_out = valid_r;

`ifdef CAPTURA_ECO_EN
  logic       eco_r;
  logic [4:0] eco_tecla_r;

  // Echo of every accepted key, whatever its effect on the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      eco_r       <= 1'b0;
      eco_tecla_r <= COD_NADA;
    end else if (tecla_ok_s) begin
      eco_r       <= 1'b1;
      eco_tecla_r <= {1'b0, tecla_s};
    end else begin
      eco_r       <= 1'b0;
      eco_tecla_r <= eco_tecla_r;
    end
  end

  assign eco       = eco_r;
  assign eco_tecla = eco_tecla_r;
`endif

endmodule

// File: doc/captura_digitos.md
# captura_digitos

Downstream consumer of the keypad scanner, running in the same 100 Hz scan-clock domain. It takes the scanner's 5-bit key code and a row-activity flag, debounces each press into exactly one accepted key event, and edits an N_DIG-digit BCD entry buffer. Digits shift in from the right, A deletes one digit, F clears, and E commits the entry to the next stage over a valid/ready handshake.

## Interface
- N_DIG, 4: digits in the entry buffer.
- ESTABLE, 3: matching active samples needed to accept a press (≥1).
- REL_CICLOS, 8: consecutive inactive cycles that mean release (≥5, longer than one 4-column scan).
- clk  in  1  scan clock (100 Hz), single clock domain.
- rst  in  1  synchronous, active-high reset.
- codigo  in  5  key code from the scanner: 0–9, A–F, 16 = none, 17 = invalid column.
- activo  in  1  high in every cycle where a row line is asserted; aligned with the `codigo` value it produced.
- digitos  out  4*N_DIG  live buffer; digit 0 is in bits [3:0] and is the most recent.
- cuenta  out  $clog2(N_DIG+1)  number of digits held.
- dato_out  out  4*N_DIG  committed entry.
- valid_out  out  1  `dato_out` is valid.
- ready_in  in  1  consumer accepts `dato_out`.
- rechazo  out  1  one-cycle pulse when a key is discarded (buffer full, or E while busy).

## Operation
- Debounce FSM states: LIBRE, CONFIRMA, PRESIONADA.
- Quiet counter `q`:
  - reset to 0 on any cycle with `activo` = 1;
  - otherwise increments, saturating at REL_CICLOS.
- LIBRE:
  - On `activo` with `codigo` < 16: latch `cand` = `codigo`, set `n` = 1, go to CONFIRMA.
  - `codigo` ≥ 16 is ignored.
- CONFIRMA:
  - On `activo` with `codigo` == `cand`: `n`++.
  - On `activo` with a different code: `cand` = `codigo`, `n` = 1.
  - When `n` reaches ESTABLE: accept `cand` and go to PRESIONADA.
  - If `q` reaches REL_CICLOS first: go to LIBRE with nothing accepted.
- PRESIONADA:
  - Accepts nothing.
  - Goes to LIBRE when `q` reaches REL_CICLOS.
  - A held key therefore never repeats.
- Accepted key actions:
  - 0–9, `cuenta` < N_DIG: `digitos` = {`digitos`[4*N_DIG-5:0], key}; `cuenta`++.
  - 0–9, `cuenta` == N_DIG: buffer unchanged; pulse `rechazo`.
  - A: `digitos` = `digitos` >> 4; `cuenta` decrements, saturating at 0.
  - F: `digitos` = 0; `cuenta` = 0.
  - E with `cuenta` = 0: no effect.
  - E when the output slot is free: `dato_out` = `digitos`, `valid_out` = 1, buffer cleared.
  - E when the slot is busy: buffer kept; pulse `rechazo`.
  - B, C, D: no effect.
- Output handshake:
  - Transfer completes on a cycle with `valid_out` & `ready_in`.
  - `dato_out` is held stable while `valid_out` = 1 and `ready_in` = 0.
  - The slot counts as free when `valid_out` = 0, or when `ready_in` = 1 in the same cycle. A simultaneous E loads new data and `valid_out` stays 1.

## Timing
- Reset values: FSM = LIBRE, `q` = 0, `n` = 0, `digitos` = 0, `cuenta` = 0, `dato_out` = 0, `valid_out` = 0, `rechazo` = 0.
- `rst` has priority over all events; asserting it mid-press returns to LIBRE.
- A press sitting in PRESIONADA when reset is released can re-trigger. This is accepted behaviour.
- Acceptance happens on the edge where `n` reaches ESTABLE. `digitos`, `cuenta`, `dato_out`, `valid_out` and `rechazo` update on that same edge and are visible in the next cycle.
- Minimum key-to-buffer latency is ESTABLE cycles after the first active sample. With the 4-phase scan the typical latency is about 4·(ESTABLE-1)+1 cycles.
- `valid_out` drops on the cycle after the handshake, unless it was reloaded in that cycle.

## Configuration
- `CAPTURA_ECO_EN` defined:
  - adds output `eco` (1 bit) and output `eco_tecla` (5 bits);
  - `eco` pulses for one cycle on every accepted key, including rejected and no-effect keys;
  - `eco_tecla` holds the last accepted code; it resets to 16.
- `CAPTURA_ECO_EN` undefined: both ports and their logic are absent; all other behaviour is identical.

## Structure
- Package `captura_pkg` holds:
  - `COD_NADA` = 16, `COD_BORRAR` = 4'hA, `COD_ENTER` = 4'hE, `COD_LIMPIAR` = 4'hF;
  - the debounce state enum `estado_t`.
- Sub-module `antirrebote_tecla` contains the FSM, `q`, `n` and `cand`. It outputs a one-cycle `tecla_ok` with `tecla[3:0]`.
- The buffer and handshake logic stay in the top module.

## Test plan
- Key 5 held for 12 scan periods, then released for 10 cycles → exactly one accept; `digitos` = 0x0005, `cuenta` = 1.
- Bounce sequence 3,7,7,7 (`activo` pulses 4 cycles apart) → only 7 is accepted, after the third matching sample.
- Keys 1,2,3,4,9 → `digitos` = 0x1234, `cuenta` = 4; the 9 pulses `rechazo`. Then A → 0x0123, `cuenta` = 3. Then F → 0, `cuenta` = 0.
- Keys 4,2,E with `ready_in` = 0 → `dato_out` = 0x0042, `valid_out` = 1, buffer 0. Then 7,E → `rechazo` pulse; buffer keeps 0x0007 and `dato_out` is unchanged.
- `valid_out` = 1 with E accepted in the same cycle as `ready_in` = 1 → `dato_out` takes the new value and `valid_out` stays 1.
- `rst` asserted while in CONFIRMA and while `valid_out` = 1 → all outputs return to their reset values on the next edge.
